// File: rtl/sigma_16p_spread.sv
`default_nettype none
// ============================================================================
//  Module      : sigma_16p_spread
//  Description : Splits a 12-bit two's-complement frame total into 16
//                sign-magnitude samples and paces them with a square-wave
//                sampling clock. Its outputs feed a sigma_16p accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module sigma_16p_spread #(
  parameter int HALF_PER = 10
) (
  input  logic        clk,
  input  logic        res,
  input  logic [11:0] data_in,
  input  logic        syn_in,
  output logic [7:0]  data_out,
  output logic        syn_out,
  output logic        busy,
  output logic        sat,
  output logic        ovr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;

  localparam logic signed [11:0] C_MAX  = 12'sd2032;
  localparam logic signed [11:0] C_MIN  = -12'sd2032;
  localparam logic [7:0]         C_LAST = 8'(HALF_PER - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [7:0]        r_phase;
  logic [3:0]        r_k;
  logic [7:0]        r_q;        // floor(T/16), two's complement
  logic [3:0]        r_r;        // T mod 16: number of samples carrying q+1
  logic [7:0]        r_data_out;
  logic              r_syn_out;
  logic              r_busy;
  logic              r_sat;
  logic              r_ovr;

  logic [7:0]        w_data_nxt;
  logic              w_syn_nxt;
  logic              w_busy_nxt;
  logic              w_sat_nxt;
  logic              w_ovr_nxt;
  logic signed [11:0] w_din_s;
  logic signed [11:0] w_clip;
  logic              w_clipped;
  logic              w_load;
  logic              w_phase_end;

  // Sample k is q+1 for k<r, else q; result encoded as sign-magnitude.
  // Zero always encodes as 0x00 because a zero value never sets the sign.
  function automatic logic [7:0] encode(input logic [7:0] q, input logic [3:0] r,
                                        input logic [3:0] k);
    logic [8:0] v;
    logic [8:0] mag;
    v   = {q[7], q} + {8'd0, (k < r)};
    mag = v[8] ? (~v + 9'd1) : v;
    return {v[8], mag[6:0]};
  endfunction

  // Clip the incoming total to the range 16 samples of +/-127 can represent.
  always_comb begin
    w_din_s   = data_in;
    w_clip    = w_din_s;
    w_clipped = 1'b0;
    if (w_din_s > C_MAX) begin
      w_clip    = C_MAX;
      w_clipped = 1'b1;
    end else if (w_din_s < C_MIN) begin
      w_clip    = C_MIN;
      w_clipped = 1'b1;
    end
  end

  assign w_load      = syn_in && (r_state == S_IDLE);
  assign w_phase_end = (r_phase == C_LAST);

  // State register plus phase counter, sample index and split operands.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= S_IDLE;
      r_phase <= 8'd0;
      r_k     <= 4'd0;
      r_q     <= 8'd0;
      r_r     <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE || w_phase_end) r_phase <= 8'd0;
      else                                  r_phase <= r_phase + 8'd1;
      if (w_load) begin
        r_k <= 4'd0;
        r_q <= w_clip[11:4];
        r_r <= w_clip[3:0];
      end else if (r_state == S_HIGH && w_phase_end) begin
        r_k <= r_k + 4'd1;
      end
    end
  end

  // Next-state: IDLE -> LOW on load, LOW <-> HIGH every HALF_PER cycles,
  // back to IDLE after the high phase of the sixteenth sample.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_load) w_state_nxt = S_LOW;
      S_LOW:   if (w_phase_end) w_state_nxt = S_HIGH;
      S_HIGH:  if (w_phase_end) w_state_nxt = (r_k == 4'd15) ? S_IDLE : S_LOW;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; data_out changes with each syn_out fall.
  always_comb begin
    w_data_nxt = r_data_out;
    w_syn_nxt  = r_syn_out;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_sat_nxt  = r_sat;
    w_ovr_nxt  = syn_in && (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        w_syn_nxt  = 1'b0;
        w_data_nxt = 8'h00;
        if (w_load) begin
          w_data_nxt = encode(w_clip[11:4], w_clip[3:0], 4'd0);
          w_sat_nxt  = w_clipped;
        end
      end
      S_LOW: begin
        if (w_phase_end) w_syn_nxt = 1'b1;
      end
      S_HIGH: begin
        if (w_phase_end) begin
          w_syn_nxt  = 1'b0;
          w_data_nxt = (r_k == 4'd15) ? 8'h00 : encode(r_q, r_r, r_k + 4'd1);
        end
      end
      default: begin
        w_syn_nxt  = 1'b0;
        w_data_nxt = 8'h00;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_data_out <= 8'h00;
      r_syn_out  <= 1'b0;
      r_busy     <= 1'b0;
      r_sat      <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_data_out <= w_data_nxt;
      r_syn_out  <= w_syn_nxt;
      r_busy     <= w_busy_nxt;
      r_sat      <= w_sat_nxt;
      r_ovr      <= w_ovr_nxt;
    end
  end

  assign data_out = r_data_out;
  assign syn_out  = r_syn_out;
  assign busy     = r_busy;
  assign sat      = r_sat;
  assign ovr      = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_sigma_16p_spread.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sigma_16p_spread
//  Description : Self-checking bench for sigma_16p_spread: table of frame
//                totals with hand-computed samples, plus overrun, reset and
//                back-to-back load sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sigma_16p_spread;

  localparam int HP    = 10;
  localparam int FRAME = 32 * HP;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic [11:0] data_in = 12'h000;
  logic        syn_in = 1'b0;
  logic [7:0]  data_out;
  logic        syn_out;
  logic        busy;
  logic        sat;
  logic        ovr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sigma_16p_spread #(.HALF_PER(HP)) dut (
    .clk      (clk),
    .res      (res),
    .data_in  (data_in),
    .syn_in   (syn_in),
    .data_out (data_out),
    .syn_out  (syn_out),
    .busy     (busy),
    .sat      (sat),
    .ovr      (ovr)
  );

  // Frame description: samples 0..n_hi-1 are hi, the rest lo.
  typedef struct {
    logic [11:0] din;
    logic [7:0]  hi;
    logic [7:0]  lo;
    int          n_hi;
    logic        sat;
    int          sum;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sm2int(input logic [7:0] c);
    return c[7] ? -int'(c[6:0]) : int'(c[6:0]);
  endfunction

  // Called at posedge+1 of an idle cycle; returns at posedge+1 of the
  // first idle cycle after the frame.
  task automatic run_frame(input vec_t v, input int idx);
    int n, rises, bad_data, bad_syn, sum, saw80;
    logic prev;
    logic [7:0] exp;
    data_in = v.din;
    syn_in  = 1'b1;
    @(posedge clk); #1;
    syn_in  = 1'b0;
    check($sformatf("v%0d busy_after_load", idx), int'(busy), 1);
    check($sformatf("v%0d sat", idx), int'(sat), int'(v.sat));
    n = 0; rises = 0; bad_data = 0; bad_syn = 0; sum = 0; saw80 = 0; prev = 1'b0;
    while (busy && n < FRAME + 20) begin
      exp = ((n / (2 * HP)) < v.n_hi) ? v.hi : v.lo;
      if (data_out != exp) bad_data++;
      if (syn_out != ((n % (2 * HP)) >= HP)) bad_syn++;
      if (data_out == 8'h80) saw80 = 1;
      if (syn_out && !prev) begin
        rises++;
        sum += sm2int(data_out);
      end
      prev = syn_out;
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("v%0d busy_cycles", idx), n, FRAME);
    check($sformatf("v%0d rises", idx), rises, 16);
    check($sformatf("v%0d bad_samples", idx), bad_data, 0);
    check($sformatf("v%0d bad_syn_timing", idx), bad_syn, 0);
    check($sformatf("v%0d decoded_sum", idx), sum, v.sum);
    check($sformatf("v%0d saw_0x80", idx), saw80, 0);
    check($sformatf("v%0d idle_data", idx), int'(data_out), 0);
    check($sformatf("v%0d idle_syn", idx), int'(syn_out), 0);
  endtask

  initial begin
    int bad, edges;
    logic prev;
    vec_t v;

    vecs[0]  = '{12'h010, 8'h01, 8'h01, 0,  1'b0, 16};
    vecs[1]  = '{12'h025, 8'h03, 8'h02, 5,  1'b0, 37};
    vecs[2]  = '{12'hFFF, 8'h00, 8'h81, 15, 1'b0, -1};
    vecs[3]  = '{12'h7FF, 8'h7F, 8'h7F, 0,  1'b1, 2032};
    vecs[4]  = '{12'h800, 8'hFF, 8'hFF, 0,  1'b1, -2032};
    vecs[5]  = '{12'h000, 8'h00, 8'h00, 0,  1'b0, 0};
    vecs[6]  = '{12'hFDB, 8'h82, 8'h83, 11, 1'b0, -37};
    vecs[7]  = '{12'h7F0, 8'h7F, 8'h7F, 0,  1'b0, 2032};
    vecs[8]  = '{12'h7F1, 8'h7F, 8'h7F, 0,  1'b1, 2032};
    vecs[9]  = '{12'h80F, 8'hFF, 8'hFF, 0,  1'b1, -2032};
    vecs[10] = '{12'h810, 8'hFF, 8'hFF, 0,  1'b0, -2032};
    vecs[11] = '{12'h7E7, 8'h7F, 8'h7E, 7,  1'b0, 2023};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst data_out", int'(data_out), 0);
    check("rst syn_out", int'(syn_out), 0);
    check("rst busy", int'(busy), 0);
    check("rst sat", int'(sat), 0);
    check("rst ovr", int'(ovr), 0);
    res = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_frame(vecs[i], i);

    // Overrun mid-frame, then asynchronous reset mid-frame
    data_in = 12'h020;
    syn_in  = 1'b1;
    @(posedge clk); #1;
    syn_in  = 1'b0;                       // first busy cycle (index 0)
    repeat (99) begin @(posedge clk); #1; end
    check("ovr idle_before", int'(ovr), 0);
    data_in = 12'h7FF;
    syn_in  = 1'b1;                       // 100th busy cycle
    @(posedge clk); #1;
    syn_in  = 1'b0;
    check("ovr pulse", int'(ovr), 1);
    check("ovr sat_unchanged", int'(sat), 0);
    @(posedge clk); #1;
    check("ovr one_cycle", int'(ovr), 0);
    bad = 0;
    for (int n = 101; n < 200; n++) begin
      if (data_out != 8'h02 || !busy) bad++;
      @(posedge clk); #1;
    end
    check("ovr frame_unchanged", bad, 0);
    #2 res = 1'b0;
    #1;
    check("async data_out", int'(data_out), 0);
    check("async syn_out", int'(syn_out), 0);
    check("async busy", int'(busy), 0);
    check("async sat", int'(sat), 0);
    check("async ovr", int'(ovr), 0);
    @(posedge clk); #1;
    res = 1'b1;
    edges = 0; bad = 0; prev = syn_out;
    for (int n = 0; n < 100; n++) begin
      if (syn_out != prev) edges++;
      if (busy || data_out != 8'h00) bad++;
      prev = syn_out;
      @(posedge clk); #1;
    end
    check("post_reset syn_edges", edges, 0);
    check("post_reset idle", bad, 0);

    // syn_in on the last busy cycle is dropped; a load on the cycle busy falls is accepted
    data_in = 12'h010;
    syn_in  = 1'b1;
    @(posedge clk); #1;
    syn_in  = 1'b0;
    repeat (FRAME - 1) begin @(posedge clk); #1; end
    check("edge last_busy", int'(busy), 1);
    data_in = 12'h7FF;
    syn_in  = 1'b1;
    @(posedge clk); #1;
    syn_in  = 1'b0;
    check("edge dropped_busy", int'(busy), 0);
    check("edge dropped_ovr", int'(ovr), 1);
    check("edge dropped_data", int'(data_out), 0);
    v = vecs[1];
    run_frame(v, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
